// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter that shares one uart_tx byte stream between requesters.
// Define ARB_WATCHDOG_EN to build the stall watchdog that force-releases a silent owner.
module uart_tx_arbiter #(
  parameter int DATA_WIDTH      = 8,
  parameter int NUM_REQ         = 2,
  parameter int WATCHDOG_CYCLES = 1024
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] s_tdata_i,
  input  logic [NUM_REQ-1:0]            s_tvalid_i,
  input  logic [NUM_REQ-1:0]            s_tlast_i,
  output logic [NUM_REQ-1:0]            s_tready_o,
  output logic [DATA_WIDTH-1:0]         m_tdata_o,
  output logic                          m_tvalid_o,
  input  logic                          m_tready_i,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          busy_o,
  output logic                          abort_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

  state_t             r_state;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   r_owner;
  logic [NUM_REQ-1:0] r_grant;
  logic               r_busy;

  logic [PTR_W-1:0]   w_rot_idx [NUM_REQ];
  logic [NUM_REQ-1:0] w_pick_oh;
  logic [PTR_W-1:0]   w_pick;
  logic               w_pick_vld;
  logic [PTR_W-1:0]   w_owner_inc;
  logic               w_fire;
  logic               w_last_fire;
  logic               w_wd_fire;
  logic               w_release;

  // Search order starts at the pointer and wraps modulo NUM_REQ.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
      logic [PTR_W:0] w_sum;
      assign w_sum          = {1'b0, r_ptr} + (PTR_W+1)'(gi);
      assign w_rot_idx[gi]  = (w_sum >= (PTR_W+1)'(NUM_REQ)) ?
                              PTR_W'(w_sum - (PTR_W+1)'(NUM_REQ)) : w_sum[PTR_W-1:0];
      assign w_pick_oh[gi]  = (w_pick == PTR_W'(gi));
    end
  endgenerate

  // Walk from the farthest offset down so the nearest requester to the pointer wins.
  always_comb begin
    w_pick     = r_ptr;
    w_pick_vld = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (s_tvalid_i[w_rot_idx[i]]) begin
        w_pick     = w_rot_idx[i];
        w_pick_vld = 1'b1;
      end
    end
  end

  assign w_owner_inc = (r_owner == PTR_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
  assign w_fire      = r_busy & s_tvalid_i[r_owner] & m_tready_i;
  assign w_last_fire = w_fire & s_tlast_i[r_owner];
  assign w_release   = w_last_fire | w_wd_fire;

  assign m_tdata_o  = s_tdata_i[r_owner*DATA_WIDTH +: DATA_WIDTH];
  assign m_tvalid_o = r_busy & s_tvalid_i[r_owner];
  assign s_tready_o = r_grant & {NUM_REQ{m_tready_i}};
  assign grant_o    = r_grant;
  assign busy_o     = r_busy;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_grant <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_vld) begin
            r_state <= ST_LOCKED;
            r_owner <= w_pick;
            r_grant <= w_pick_oh;
            r_busy  <= 1'b1;
          end
        end
        ST_LOCKED: begin
          if (w_release) begin
            r_state <= ST_IDLE;
            r_ptr   <= w_owner_inc;
            r_grant <= '0;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef ARB_WATCHDOG_EN
  localparam int CNT_W = $clog2(WATCHDOG_CYCLES) + 1;

  logic [CNT_W-1:0] r_wd_cnt;
  logic             r_abort;

  // Only an owner that stops presenting data counts; uart_tx backpressure never does.
  assign w_wd_fire = r_busy & ~s_tvalid_i[r_owner] &
                     (r_wd_cnt == CNT_W'(WATCHDOG_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wd_cnt <= '0;
      r_abort  <= 1'b0;
    end else begin
      r_abort <= w_wd_fire;
      if (!r_busy || w_fire || w_wd_fire) begin
        r_wd_cnt <= '0;
      end else if (!s_tvalid_i[r_owner]) begin
        r_wd_cnt <= r_wd_cnt + 1'b1;
      end
    end
  end

  assign abort_o = r_abort;
`else
  logic w_unused_wd;
  assign w_unused_wd = (WATCHDOG_CYCLES > 0);
  assign w_wd_fire   = 1'b0;
  assign abort_o     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queue-driven requesters, beat scoreboard, cycle-exact grant checks.
// Watchdog scenario runs when ARB_WATCHDOG_EN is defined (WATCHDOG_CYCLES=16).
module tb_uart_tx_arbiter;
  localparam int DW = 8;
  localparam int NR = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR*DW-1:0] s_tdata;
  logic [NR-1:0] s_tvalid;
  logic [NR-1:0] s_tlast;
  logic [NR-1:0] s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic [NR-1:0] grant;
  logic          busy;
  logic          abort;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .WATCHDOG_CYCLES(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .s_tdata_i(s_tdata), .s_tvalid_i(s_tvalid), .s_tlast_i(s_tlast), .s_tready_o(s_tready),
    .m_tdata_o(m_tdata), .m_tvalid_o(m_tvalid), .m_tready_i(m_tready),
    .grant_o(grant), .busy_o(busy), .abort_o(abort)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Each entry is {last, data}.
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  int         obs_req[$];
  logic [7:0] obs_data[$];
  int         obs_cyc[$];
  int         exp_req[$];
  logic [7:0] exp_data[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, want);
    end
  endtask

  task automatic present();
    s_tvalid[0] = (q0.size() != 0);
    {s_tlast[0], s_tdata[7:0]}  = (q0.size() != 0) ? q0[0] : 9'h0;
    s_tvalid[1] = (q1.size() != 0);
    {s_tlast[1], s_tdata[15:8]} = (q1.size() != 0) ? q1[0] : 9'h0;
  endtask

  task automatic step();
    logic hs0, hs1;
    present();
    @(negedge clk);
    hs0 = s_tvalid[0] & s_tready[0];
    hs1 = s_tvalid[1] & s_tready[1];
    if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
      obs_req.push_back(grant[1] ? 1 : (grant[0] ? 0 : 7));
      obs_data.push_back(m_tdata);
      obs_cyc.push_back(cyc);
      $display("beat cyc=%0d grant=%b data=%02h", cyc, grant, m_tdata);
    end
    @(posedge clk);
    #1;
    if (hs0) void'(q0.pop_front());
    if (hs1) void'(q1.pop_front());
    cyc++;
  endtask

  task automatic expect_beat(input int r, input logic [7:0] d);
    exp_req.push_back(r);
    exp_data.push_back(d);
  endtask

  task automatic compare_sb(input string tag);
    chk({tag, "_count"}, obs_req.size(), exp_req.size());
    for (int i = 0; i < exp_req.size() && i < obs_req.size(); i++) begin
      chk({tag, "_req"}, obs_req[i], exp_req[i]);
      chk({tag, "_data"}, obs_data[i], exp_data[i]);
    end
    obs_req.delete(); obs_data.delete(); obs_cyc.delete();
    exp_req.delete(); exp_data.delete();
  endtask

  task automatic run_until_idle(input string tag);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || busy !== 1'b0) && n < 400) begin
      step();
      n++;
    end
    chk({tag, "_drained"}, q0.size() + q1.size(), 0);
  endtask

  task automatic do_reset();
    q0.delete(); q1.delete();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] cont_g [10];
    cont_g = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00};
    rst = 1'b1; m_tready = 1'b1; s_tvalid = '0; s_tlast = '0; s_tdata = '0;

    do_reset();
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mvalid", m_tvalid, 0);
    chk("rst_sready", s_tready, 0);
    chk("rst_abort", abort, 0);

    // Single requester, 3-byte packet.
    q0.push_back(9'h0EC); q0.push_back(9'h001); q0.push_back(9'h102);
    step();
    chk("single_grant", grant, 2'b01);
    chk("single_busy", busy, 1);
    step(); step(); step();
    chk("single_busy_drop", busy, 0);
    chk("single_grant_drop", grant, 0);
    chk("single_consec", (obs_cyc.size() == 3) ? obs_cyc[2] - obs_cyc[0] : -1, 2);
    expect_beat(0, 8'hEC); expect_beat(0, 8'h01); expect_beat(0, 8'h02);
    compare_sb("single");
    // Pointer now at 1: req1 beats req0.
    q0.push_back(9'h111); q1.push_back(9'h122);
    run_until_idle("ptr1");
    expect_beat(1, 8'h22); expect_beat(0, 8'h11);
    compare_sb("ptr1");

    // Contention from reset, 4 bytes each.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      q0.push_back({i == 3, 8'(8'hA0 + i)});
      q1.push_back({i == 3, 8'(8'hB0 + i)});
    end
    for (int i = 0; i < 10; i++) begin
      step();
      chk("cont_grant", grant, cont_g[i]);
    end
    for (int i = 0; i < 4; i++) expect_beat(0, 8'(8'hA0 + i));
    for (int i = 0; i < 4; i++) expect_beat(1, 8'(8'hB0 + i));
    compare_sb("cont");

    // Fairness: 5 single-byte packets each, must alternate.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      q0.push_back({1'b1, 8'(8'h10 + i)});
      q1.push_back({1'b1, 8'(8'h20 + i)});
      expect_beat(0, 8'(8'h10 + i));
      expect_beat(1, 8'(8'h20 + i));
    end
    run_until_idle("fair");
    compare_sb("fair");

    // Backpressure for 33 cycles mid-packet.
    do_reset();
    q0.push_back(9'h030); q0.push_back(9'h031); q0.push_back(9'h032); q0.push_back(9'h133);
    step(); step(); step();
    m_tready = 1'b0;
    for (int i = 0; i < 33; i++) begin
      step();
      chk("bp_grant", grant, 2'b01);
      chk("bp_valid", m_tvalid, 1);
      chk("bp_data", m_tdata, 8'h32);
    end
    m_tready = 1'b1;
    run_until_idle("bp");
    for (int i = 0; i < 4; i++) expect_beat(0, 8'(8'h30 + i));
    compare_sb("bp");

    // Reset mid-packet after moving the pointer to 1.
    do_reset();
    q0.push_back(9'h140);
    run_until_idle("rstpre");
    q0.push_back(9'h041); q0.push_back(9'h042); q0.push_back(9'h043); q0.push_back(9'h144);
    step(); step(); step();
    rst = 1'b1; m_tready = 1'b0;
    step();
    chk("midrst_grant", grant, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_mvalid", m_tvalid, 0);
    chk("midrst_sready", s_tready, 0);
    rst = 1'b0; m_tready = 1'b1;
    q0.delete();
    expect_beat(0, 8'h40); expect_beat(0, 8'h41); expect_beat(0, 8'h42);
    compare_sb("midrst");
    q0.push_back(9'h150); q1.push_back(9'h160);
    run_until_idle("midrst_ptr");
    expect_beat(0, 8'h50); expect_beat(1, 8'h60);
    compare_sb("midrst_ptr");

`ifdef ARB_WATCHDOG_EN
    // req1 goes silent without tlast; req0 waits behind it.
    do_reset();
    q1.push_back(9'h055);
    step();
    chk("wd_grant1", grant, 2'b10);
    step();
    q0.push_back(9'h166);
    for (int i = 0; i < 15; i++) begin
      step();
      chk("wd_hold", grant, 2'b10);
      chk("wd_abort_low", abort, 0);
    end
    step();
    chk("wd_abort", abort, 1);
    chk("wd_grant_drop", grant, 0);
    step();
    chk("wd_abort_pulse", abort, 0);
    chk("wd_next_grant", grant, 2'b01);
    run_until_idle("wd");
    expect_beat(1, 8'h55); expect_beat(0, 8'h66);
    compare_sb("wd");
`else
    // Without the watchdog a silent owner keeps the grant.
    do_reset();
    q1.push_back(9'h055);
    step(); step();
    q0.push_back(9'h166);
    for (int i = 0; i < 20; i++) step();
    chk("nowd_hold", grant, 2'b10);
    chk("nowd_abort", abort, 0);
    expect_beat(1, 8'h55);
    compare_sb("nowd");
    do_reset();
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
